// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with registered one-hot grant, owner release and hold timeout.
// The release input is named rel because "release" is a reserved word in SystemVerilog.
module rr_onehot_arbiter #(
    parameter int IDXW     = 2,
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 15,
    parameter int CNTW     = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            rel,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_vld,
    output logic            timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNTW-1:0] HOLD_MAX  = CNTW'(MAX_HOLD);
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] sel;
    logic [IDXW-1:0] idx;
    logic [CNTW-1:0] cnt;
    logic            end_rel;
    logic            end_to;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        sel = ptr;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = ptr + IDXW'(i);
            if (req[idx]) sel = idx;
        end
    end

    assign end_rel = rel | ~req[grant_idx];
    assign end_to  = (MAX_HOLD != 0) && (cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            grant     <= '0;
            grant_idx <= '0;
            grant_vld <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant     <= NREQ'(1) << sel;
                        grant_idx <= sel;
                        grant_vld <= 1'b1;
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (end_rel || end_to) begin
                        grant     <= '0;
                        grant_vld <= 1'b0;
                        ptr       <= grant_idx + 1'b1;
                        cnt       <= '0;
                        state     <= IDLE;
                        // A coincident release takes precedence over the timeout.
                        timeout   <= end_to && !end_rel;
                    end else if (cnt != HOLD_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed and randomised checks for rr_onehot_arbiter (NREQ=4, MAX_HOLD=15).
module tb_rr_onehot_arbiter;

    localparam int LIMIT = 3 * 16;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       rel;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_vld;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    rr_onehot_arbiter #(.IDXW(2), .NREQ(4), .MAX_HOLD(15), .CNTW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rel       (rel),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic v, input logic t);
        chk({tag, ".grant"}, {28'd0, grant}, {28'd0, g});
        chk({tag, ".vld"}, {31'd0, grant_vld}, {31'd0, v});
        chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, t});
    endtask

    task automatic chk_idx(input string tag, input logic [1:0] i);
        chk({tag, ".idx"}, {30'd0, grant_idx}, {30'd0, i});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_rot [5];
    logic [1:0] idx_rot [5];
    int         wait_cnt [4];
    int         worst;

    initial begin
        exp_rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        idx_rot = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst_n = 1'b0;
        req   = 4'b0000;
        rel   = 1'b0;
        #3;
        chk_out("reset0", 4'b0000, 1'b0, 1'b0);
        chk_idx("reset0", 2'd0);
        #4 rst_n = 1'b1;

        step();
        chk_out("idle_noreq", 4'b0000, 1'b0, 1'b0);

        // Rotation; the first grant also sees a release pulse while idle.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            rel = (k == 0);
            step();
            rel = 1'b0;
            chk_out($sformatf("rot%0d", k), exp_rot[k], 1'b1, 1'b0);
            chk_idx($sformatf("rot%0d", k), idx_rot[k]);
            step();
            chk_out($sformatf("rot%0d_hold", k), exp_rot[k], 1'b1, 1'b0);
            rel = 1'b1;
            step();
            chk_out($sformatf("rot%0d_gap", k), 4'b0000, 1'b0, 1'b0);
        end
        rel = 1'b0;

        // Wrap and skip: ptr=1 here.
        req = 4'b0100;
        step();
        chk_out("wrap_a", 4'b0100, 1'b1, 1'b0);
        chk_idx("wrap_a", 2'd2);
        rel = 1'b1; req = 4'b0101;
        step();
        chk_out("wrap_gap", 4'b0000, 1'b0, 1'b0);
        rel = 1'b0;
        step();
        chk_out("wrap_b", 4'b0001, 1'b1, 1'b0);
        chk_idx("wrap_b", 2'd0);
        rel = 1'b1;
        step();
        rel = 1'b0;
        step();
        chk_out("wrap_c", 4'b0100, 1'b1, 1'b0);
        chk_idx("wrap_c", 2'd2);
        rel = 1'b1; req = 4'b0000;
        step();
        rel = 1'b0;
        chk_out("wrap_end", 4'b0000, 1'b0, 1'b0);

        // Timeout: grant held 15 cycles then revoked with a one-cycle pulse.
        req = 4'b0010;
        step();
        chk_out("to_grant", 4'b0010, 1'b1, 1'b0);
        chk_idx("to_grant", 2'd1);
        for (int k = 1; k < 15; k++) begin
            step();
            chk_out($sformatf("to_hold%0d", k), 4'b0010, 1'b1, 1'b0);
        end
        step();
        chk_out("to_fire", 4'b0000, 1'b0, 1'b1);
        step();
        chk_out("to_regrant", 4'b0010, 1'b1, 1'b0);
        for (int k = 1; k < 15; k++) begin
            step();
            chk_out($sformatf("to2_hold%0d", k), 4'b0010, 1'b1, 1'b0);
        end
        rel = 1'b1;
        step();
        chk_out("to_with_rel", 4'b0000, 1'b0, 1'b0);
        rel = 1'b0; req = 4'b0000;

        // Implicit release: ptr=2 here.
        req = 4'b0100;
        step();
        chk_out("imp_grant", 4'b0100, 1'b1, 1'b0);
        chk_idx("imp_grant", 2'd2);
        req = 4'b1111;
        step();
        chk_out("imp_ignore", 4'b0100, 1'b1, 1'b0);
        req = 4'b1011;
        step();
        chk_out("imp_drop", 4'b0000, 1'b0, 1'b0);
        step();
        chk_out("imp_next", 4'b1000, 1'b1, 1'b0);
        chk_idx("imp_next", 2'd3);
        req = 4'b0000;
        step();
        chk_out("imp_end", 4'b0000, 1'b0, 1'b0);

        // Reset mid-grant with a nonzero pointer; scan restarts from 0.
        req = 4'b0010;
        step();
        rel = 1'b1;
        step();
        rel = 1'b0; req = 4'b0100;
        step();
        chk_out("rst_pre", 4'b0100, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("rst_mid", 4'b0000, 1'b0, 1'b0);
        chk_idx("rst_mid", 2'd0);
        req = 4'b1010;
        #2 rst_n = 1'b1;
        step();
        chk_out("rst_first", 4'b0010, 1'b1, 1'b0);
        chk_idx("rst_first", 2'd1);
        rel = 1'b1; req = 4'b1000;
        step();
        rel = 1'b0;
        step();
        chk_out("rst2_pre", 4'b1000, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("rst2_mid", 4'b0000, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        step();
        chk_out("rst2_first", 4'b1000, 1'b1, 1'b0);
        chk_idx("rst2_first", 2'd3);
        req = 4'b0000;
        step();
        chk_out("rst2_end", 4'b0000, 1'b0, 1'b0);

        // Randomised run: invariants and starvation bound every cycle.
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            step();
            chk("inv_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
            chk("inv_vld", {31'd0, grant_vld}, {31'd0, |grant});
            chk("inv_idx", {28'd0, grant}, grant_vld ? (32'd1 << grant_idx) : 32'd0);
            worst = 0;
            for (int i = 0; i < 4; i++) begin
                if (grant[i])    wait_cnt[i] = 0;
                else if (req[i]) wait_cnt[i]++;
                else             wait_cnt[i] = 0;
                if (wait_cnt[i] > worst) worst = wait_cnt[i];
            end
            chk("starve", {31'd0, worst <= LIMIT}, 32'd1);
            for (int i = 0; i < 4; i++) begin
                if (grant[i]) begin
                    if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                end
            end
            rel = ($urandom_range(0, 7) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
